// File: rtl/sm83_mem_pkg.sv
// Shared definitions for the SM83 memory-side bus responder: region map,
// BOOT register address, read-source select and responder FSM states.
// ECHO_RAM_EN (optional define) makes 0xE000-0xFDFF alias WRAM.
package sm83_mem_pkg;

  localparam logic [15:0] ROM_LIMIT     = 16'h00FF;
  localparam logic [15:0] WRAM_BASE     = 16'hC000;
  localparam logic [15:0] WRAM_LIMIT    = 16'hDFFF;
  localparam logic [15:0] ECHO_BASE     = 16'hE000;
  localparam logic [15:0] ECHO_LIMIT    = 16'hFDFF;
  localparam logic [15:0] BOOT_REG_ADDR = 16'hFF50;
  localparam logic [15:0] HRAM_BASE     = 16'hFF80;
  localparam logic [15:0] HRAM_LIMIT    = 16'hFFFE;

  typedef enum logic [2:0] {SRC_ROM, SRC_WRAM, SRC_HRAM, SRC_BOOT, SRC_NONE} src_e;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DRIVE} state_e;

  // Region decode in priority order; echo folds onto WRAM when enabled.
  function automatic src_e decode_src(input logic [15:0] a, input logic boot);
    if (boot && a <= ROM_LIMIT) return SRC_ROM;
    if (a >= WRAM_BASE && a <= WRAM_LIMIT) return SRC_WRAM;
`ifdef ECHO_RAM_EN
    if (a >= ECHO_BASE && a <= ECHO_LIMIT) return SRC_WRAM;
`endif
    if (a == BOOT_REG_ADDR) return SRC_BOOT;
    if (a >= HRAM_BASE && a <= HRAM_LIMIT) return SRC_HRAM;
    return SRC_NONE;
  endfunction

endpackage

// File: rtl/wram_sp.sv
// Single-port synchronous work RAM: registered read, write-first.
module wram_sp #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  // Write-first port: a write also presents the new byte on rdata.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_bus_responder.sv
// SM83 memory-side bus responder: boot ROM overlay, WRAM (+echo), BOOT
// register at 0xFF50 and HRAM. Drives data_bus only while serving a read.
// Optional define ECHO_RAM_EN: 0xE000-0xFDFF aliases WRAM via addr[12:0];
// without it that range is unmapped.
module mem_bus_responder
  import sm83_mem_pkg::*;
#(
  parameter int WRAM_AW    = 13,
  parameter int HRAM_DEPTH = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_cs,
  input  logic        mem_oe,
  input  logic        mem_we,
  input  logic [15:0] addr_bus,
  inout  wire  [7:0]  data_bus,
  output logic [7:0]  rom_addr,
  input  logic [7:0]  rom_data,
  output logic        boot_active,
  output logic        bus_err
);

  localparam int HRAM_IW = $clog2(HRAM_DEPTH);

  state_e              state;
  src_e                lat_src;
  logic [15:0]         lat_addr;
  src_e                cur_src;
  logic                cs_oe, illegal, wr_req, drive;
  logic [7:0]          wdata, rdata, wram_q, hram_q;
  logic [HRAM_IW-1:0]  hram_idx;
  logic [7:0]          hram [HRAM_DEPTH];

  assign cs_oe    = mem_cs & mem_oe;
  assign illegal  = cs_oe & mem_we;
  assign wr_req   = mem_cs & mem_we & ~mem_oe;
  assign wdata    = data_bus;
  assign rom_addr = addr_bus[7:0];
  assign cur_src  = decode_src(addr_bus, boot_active);
  // HRAM_BASE has its low bits clear, so the offset is just the low address bits.
  assign hram_idx = addr_bus[HRAM_IW-1:0];

  wram_sp #(.AW(WRAM_AW)) u_wram (
    .clk   (clk),
    .we    (wr_req && cur_src == SRC_WRAM),
    .addr  (addr_bus[WRAM_AW-1:0]),
    .wdata (wdata),
    .rdata (wram_q)
  );

  // HRAM: write-first registered read, only while addressed (keeps index in range).
  always_ff @(posedge clk) begin
    if (cur_src == SRC_HRAM) begin
      if (wr_req) begin
        hram[hram_idx] <= wdata;
        hram_q         <= wdata;
      end else begin
        hram_q         <= hram[hram_idx];
      end
    end
  end

  // Sticky boot-ROM disable: any nonzero write to 0xFF50 clears it until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      boot_active <= 1'b1;
    else if (wr_req && addr_bus == BOOT_REG_ADDR && wdata != 8'h00)
      boot_active <= 1'b0;
  end

  // Read FSM plus illegal-strobe pulse; any dropped strobe or conflict returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lat_addr <= 16'h0000;
      lat_src  <= SRC_NONE;
      bus_err  <= 1'b0;
    end else begin
      bus_err <= illegal;
      if (!cs_oe || mem_we) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            state    <= RD_WAIT;
            lat_addr <= addr_bus;
            lat_src  <= cur_src;
          end
          RD_WAIT: state <= RD_DRIVE;
          RD_DRIVE: begin
            // New address under held strobes: release one cycle, re-fetch.
            if (addr_bus != lat_addr) begin
              state    <= RD_WAIT;
              lat_addr <= addr_bus;
              lat_src  <= cur_src;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Read data select from the source latched at request time.
  always_comb begin
    rdata = 8'hFF;
    case (lat_src)
      SRC_ROM:  rdata = rom_data;
      SRC_WRAM: rdata = wram_q;
      SRC_HRAM: rdata = hram_q;
      SRC_BOOT: rdata = {7'h7F, ~boot_active};
      default:  rdata = 8'hFF;
    endcase
  end

  // Strobe gating is combinational so the bus lets go without waiting for an edge.
  assign drive    = (state == RD_DRIVE) && cs_oe && !mem_we;
  assign data_bus = drive ? rdata : 8'hzz;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: directed table, multi-cycle
// corner sequences, then randomized traffic against a behavioural model.
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs, oe, we;
  logic [15:0] addr;
  logic [7:0]  tb_d;
  logic        tb_drv;
  wire  [7:0]  data_bus;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        boot_active, bus_err;

  int total = 0;
  int bad   = 0;

  assign data_bus = tb_drv ? tb_d : 8'hzz;

  mem_bus_responder dut (
    .clk         (clk),
    .rst         (rst),
    .mem_cs      (cs),
    .mem_oe      (oe),
    .mem_we      (we),
    .addr_bus    (addr),
    .data_bus    (data_bus),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .boot_active (boot_active),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [7:0] a);
    return 8'h80 | (a ^ 8'h15);
  endfunction

  // 1-cycle-latency boot ROM stand-in
  always @(posedge clk) rom_data <= rom_byte(rom_addr);

  // ---------------- behavioural reference model ----------------
  logic [7:0] m_wram [int];
  logic [7:0] m_hram [int];
  bit         m_boot;

  function automatic void mdl_write(input logic [15:0] a, input logic [7:0] d);
    if (a inside {[16'hC000:16'hDFFF]}) m_wram[int'(a[12:0])] = d;
`ifdef ECHO_RAM_EN
    else if (a inside {[16'hE000:16'hFDFF]}) m_wram[int'(a[12:0])] = d;
`endif
    else if (a == 16'hFF50) begin if (d != 8'h00) m_boot = 1'b0; end
    else if (a inside {[16'hFF80:16'hFFFE]}) m_hram[int'(a - 16'hFF80)] = d;
  endfunction

  // Returns 0 when the expected byte is unknown (RAM never written).
  function automatic bit mdl_read(input logic [15:0] a, output logic [7:0] v);
    v = 8'hFF;
    if (m_boot && a < 16'h0100) v = rom_byte(a[7:0]);
    else if (a inside {[16'hC000:16'hDFFF]}) begin
      if (!m_wram.exists(int'(a[12:0]))) return 1'b0;
      v = m_wram[int'(a[12:0])];
    end
`ifdef ECHO_RAM_EN
    else if (a inside {[16'hE000:16'hFDFF]}) begin
      if (!m_wram.exists(int'(a[12:0]))) return 1'b0;
      v = m_wram[int'(a[12:0])];
    end
`endif
    else if (a == 16'hFF50) v = {7'h7F, ~m_boot};
    else if (a inside {[16'hFF80:16'hFFFE]}) begin
      if (!m_hram.exists(int'(a - 16'hFF80))) return 1'b0;
      v = m_hram[int'(a - 16'hFF80)];
    end
    return 1'b1;
  endfunction

  // ---------------- helpers ----------------
  function automatic bit is_hiz(input logic [7:0] v);
    // 4-state simulators see z; 2-state ones resolve an undriven net to 0.
    return (v === 8'hzz) || (v === 8'h00);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; tb_d = d; tb_drv = 1'b1; cs = 1'b1; we = 1'b1; oe = 1'b0;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0; tb_drv = 1'b0;
    mdl_write(a, d);
  endtask

  task automatic do_read(input logic [15:0] a, output logic [7:0] v, output bit gap_hiz);
    addr = a; cs = 1'b1; oe = 1'b1; we = 1'b0;
    @(posedge clk); #1;
    gap_hiz = is_hiz(data_bus);
    @(posedge clk); #1;
    v = data_bus;
    cs = 1'b0; oe = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  exp;
    logic        exp_boot;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v, e;
    bit         g;
    logic [7:0] echo_exp;

    cs = 0; oe = 0; we = 0; addr = 16'h0000; tb_d = 8'h00; tb_drv = 0;
    m_boot = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_boot_active", {7'h0, boot_active}, 8'h01);
    chk("rst_bus_err", {7'h0, bus_err}, 8'h00);
    chk("rst_bus_hiz", {7'h0, is_hiz(data_bus)}, 8'h01);
    rst = 1'b0;
    @(posedge clk); #1;

`ifdef ECHO_RAM_EN
    echo_exp = 8'h5A;
`else
    echo_exp = 8'hFF;
`endif
    // ---------------- directed table ----------------
    tbl.push_back('{1'b0, 16'h0000, 8'h00, rom_byte(8'h00), 1'b1});
    tbl.push_back('{1'b0, 16'h0042, 8'h00, rom_byte(8'h42), 1'b1});
    tbl.push_back('{1'b1, 16'hC123, 8'h5A, 8'h00,           1'b1});
    tbl.push_back('{1'b0, 16'hC123, 8'h00, 8'h5A,           1'b1});
    tbl.push_back('{1'b0, 16'hE123, 8'h00, echo_exp,        1'b1});
    tbl.push_back('{1'b0, 16'hFF50, 8'h00, 8'hFE,           1'b1});
    tbl.push_back('{1'b1, 16'hFF50, 8'h00, 8'h00,           1'b1});
    tbl.push_back('{1'b0, 16'h0000, 8'h00, rom_byte(8'h00), 1'b1});
    tbl.push_back('{1'b1, 16'hFF50, 8'h01, 8'h00,           1'b0});
    tbl.push_back('{1'b0, 16'h0000, 8'h00, 8'hFF,           1'b0});
    tbl.push_back('{1'b0, 16'hFF50, 8'h00, 8'hFF,           1'b0});
    tbl.push_back('{1'b1, 16'hFF50, 8'h00, 8'h00,           1'b0});
    tbl.push_back('{1'b1, 16'hFFFE, 8'hA5, 8'h00,           1'b0});
    tbl.push_back('{1'b1, 16'hFF80, 8'h3C, 8'h00,           1'b0});
    tbl.push_back('{1'b0, 16'hFFFE, 8'h00, 8'hA5,           1'b0});
    tbl.push_back('{1'b0, 16'hFF80, 8'h00, 8'h3C,           1'b0});
    tbl.push_back('{1'b0, 16'hFFFF, 8'h00, 8'hFF,           1'b0});
    tbl.push_back('{1'b0, 16'h8000, 8'h00, 8'hFF,           1'b0});

    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].a, tbl[i].d);
      end else begin
        do_read(tbl[i].a, v, g);
        chk($sformatf("tbl%0d_rd_%h", i, tbl[i].a), v, tbl[i].exp);
        chk($sformatf("tbl%0d_wait_hiz", i), {7'h0, g}, 8'h01);
      end
      chk($sformatf("tbl%0d_boot", i), {7'h0, boot_active}, {7'h0, tbl[i].exp_boot});
      chk($sformatf("tbl%0d_bus_err", i), {7'h0, bus_err}, 8'h00);
    end

    // ---------------- illegal strobe combination ----------------
    do_write(16'hC000, 8'h11);
    addr = 16'hC000; tb_d = 8'h77; tb_drv = 1'b1; cs = 1; oe = 1; we = 1;
    @(posedge clk); #1;
    chk("ill_bus_err_pulse", {7'h0, bus_err}, 8'h01);
    cs = 0; oe = 0; we = 0; tb_drv = 1'b0;
    @(posedge clk); #1;
    chk("ill_bus_err_clear", {7'h0, bus_err}, 8'h00);
    // conflict arriving mid-read must release the bus
    addr = 16'hC000; cs = 1; oe = 1; we = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ill_pre_drive", data_bus, 8'h11);
    we = 1;
    @(posedge clk); #1;
    chk("ill_bus_hiz", {7'h0, is_hiz(data_bus)}, 8'h01);
    chk("ill_bus_err_mid", {7'h0, bus_err}, 8'h01);
    cs = 0; oe = 0; we = 0;
    @(posedge clk); #1;
    do_read(16'hC000, v, g);
    chk("ill_no_write", v, 8'h11);

    // ---------------- back-to-back read with address step ----------------
    do_write(16'hC000, 8'h21);
    do_write(16'hC001, 8'h43);
    addr = 16'hC000; cs = 1; oe = 1; we = 0;
    @(posedge clk); #1;
    chk("b2b_wait_hiz", {7'h0, is_hiz(data_bus)}, 8'h01);
    @(posedge clk); #1;
    chk("b2b_first", data_bus, 8'h21);
    @(posedge clk); #1;
    chk("b2b_first_held", data_bus, 8'h21);
    addr = 16'hC001;
    @(posedge clk); #1;
    chk("b2b_gap_hiz", {7'h0, is_hiz(data_bus)}, 8'h01);
    @(posedge clk); #1;
    chk("b2b_second", data_bus, 8'h43);
    oe = 1'b0; #1;
    chk("b2b_release_comb", {7'h0, is_hiz(data_bus)}, 8'h01);
    cs = 1'b0;
    @(posedge clk); #1;

    // ---------------- reset during RD_DRIVE ----------------
    do_write(16'hFF80, 8'h3C);
    addr = 16'hFF80; cs = 1; oe = 1; we = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstmid_drive", data_bus, 8'h3C);
    chk("rstmid_boot_before", {7'h0, boot_active}, 8'h00);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_bus_hiz", {7'h0, is_hiz(data_bus)}, 8'h01);
    chk("rstmid_boot", {7'h0, boot_active}, 8'h01);
    cs = 0; oe = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_boot = 1'b1;
    @(posedge clk); #1;
    do_read(16'h0000, v, g);
    chk("rstmid_rom_back", v, rom_byte(8'h00));
    do_read(16'hFF80, v, g);
    chk("rstmid_hram_kept", v, 8'h3C);

    // ---------------- randomized traffic vs model ----------------
    for (int i = 0; i < 64; i++) do_write(16'hC000 + 16'(i), 8'($urandom));
    for (int i = 0; i < 127; i++) do_write(16'hFF80 + 16'(i), 8'($urandom));
    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      case ($urandom_range(0, 5))
        0: a = 16'hC000 + 16'($urandom_range(0, 63));
        1: a = 16'hE000 + 16'($urandom_range(0, 63));
        2: a = 16'hFF80 + 16'($urandom_range(0, 127));
        3: a = 16'($urandom_range(0, 255));
        4: a = 16'hFF50;
        default: a = 16'($urandom);
      endcase
      if ($urandom_range(0, 1) == 0) begin
        // keep the ROM overlay alive for a while so ROM reads get exercised
        if (a == 16'hFF50 && n < 200) do_write(a, 8'h00);
        else do_write(a, 8'($urandom));
      end else begin
        do_read(a, v, g);
        if (mdl_read(a, e)) chk($sformatf("rnd%0d_rd_%h", n, a), v, e);
        chk($sformatf("rnd%0d_boot", n), {7'h0, boot_active}, {7'h0, m_boot});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
# mem_bus_responder

Memory-side responder for the SM83 CPU's shared 8-bit data / 16-bit address bus. It answers CPU read and write strobes for the boot ROM overlay, work RAM with its echo region, and high RAM, and drives the tri-state data bus only while a read is being served. It sits between `cpu_top` and the storage blocks, including the existing 1-cycle-latency `bootrom` IP. It also owns the sticky boot-ROM-disable register at 0xFF50.

## Interface
- `WRAM_AW`, default 13: WRAM address width, 8 KiB.
- `HRAM_DEPTH`, default 127: HRAM bytes at 0xFF80–0xFFFE.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_cs` in 1: CPU chip select.
- `mem_oe` in 1: CPU read strobe.
- `mem_we` in 1: CPU write strobe.
- `addr_bus` in 16: CPU address.
- `data_bus` inout 8: shared data bus; driven only in RD_DRIVE, otherwise high-Z.
- `rom_addr` out 8: to bootrom; equals `addr_bus[7:0]`, combinational.
- `rom_data` in 8: bootrom output, valid 1 cycle after `rom_addr`.
- `boot_active` out 1: 1 = ROM overlays 0x0000–0x00FF.
- `bus_err` out 1: 1-cycle pulse on an illegal strobe combination.

## Operation
- Decode, in priority order:
  - 0x0000–0x00FF with `boot_active` → ROM.
  - 0xC000–0xDFFF → WRAM.
  - 0xE000–0xFDFF → echo.
  - 0xFF50 → BOOT register.
  - 0xFF80–0xFFFE → HRAM.
  - Everything else → unmapped.
- Unmapped reads return 0xFF. Unmapped writes are ignored.
- FSM states are IDLE, RD_WAIT and RD_DRIVE.
  - IDLE → RD_WAIT: on a sampled `cs & oe & !we`. Latch the address and the source select.
  - RD_WAIT → RD_DRIVE: unconditional, provided `cs & oe` are still high.
  - RD_DRIVE → RD_WAIT: if `addr_bus` differs from the latched address while `cs & oe` are held. This is a back-to-back read: the bus is released for one cycle.
  - Any state → IDLE: when `cs` or `oe` is sampled low.
- Drive gating: `data_bus = (state==RD_DRIVE && cs && oe) ? rdata : 'z`. The `cs`/`oe` gating is combinational, so the bus is released as soon as either strobe drops, with no wait for an edge.
- `rdata` is muxed from `rom_data`, the WRAM read port, the HRAM read register, BOOT as {7'b1111111, ~boot_active}, or 0xFF, selected by the latched select.
- Writes: a sampled `cs & we & !oe` commits on that same rising edge. No FSM involvement.
- BOOT register behaviour:
  - Any write to 0xFF50 with nonzero data clears `boot_active`.
  - Once cleared it stays cleared until reset.
  - Writing 0x00 has no effect.
- Writes to the ROM range are ignored.
- Simultaneous `cs & oe & we`:
  - No write and no drive.
  - FSM forced to IDLE.
  - `bus_err` = 1 for the following cycle.

## Timing
- Reset values:
  - state = IDLE
  - `data_bus` high-Z
  - `boot_active` = 1
  - `bus_err` = 0
  - latched address = 0x0000
- RAM contents are not reset.
- Read latency: request sampled at edge N; data is driven on the bus from edge N+1 until the strobe drops or the address changes.
- Back-to-back reads to different addresses: 2 cycles each, with one high-Z gap cycle between them.
- Write latency: 0. A read of the same address issued on the next cycle returns the new value.
- Reset asserted mid-read: the bus is released asynchronously and the FSM goes to IDLE. `boot_active` returns to 1.

## Configuration
- `ECHO_RAM_EN` defined:
  - 0xE000–0xFDFF aliases WRAM through `addr[12:0]` for both reads and writes.
- `ECHO_RAM_EN` undefined:
  - The range decodes as unmapped: reads return 0xFF and writes are ignored.
  - No echo decode logic is generated.

## Structure
- The shared package `sm83_mem_pkg` holds the region base/limit constants, the `BOOT_REG_ADDR` (0xFF50) constant, the source-select enum {SRC_ROM, SRC_WRAM, SRC_HRAM, SRC_BOOT, SRC_NONE}, and the FSM state enum.
- One sub-module, `wram_sp`: a single-port synchronous RAM, 2^WRAM_AW × 8, with registered read and write-first behaviour.
- HRAM is an inline register array with a registered read.

## Test plan
- Reset, then read 0x0000 with `cs=oe=1`:
  - `data_bus` is high-Z during RD_WAIT.
  - `data_bus` = ROM byte 0 from the next edge.
  - `boot_active` = 1.
- Write 0x5A to 0xC123, then read 0xC123:
  - Returns 0x5A.
  - Reading 0xE123 also returns 0x5A with `ECHO_RAM_EN`, and 0xFF without it.
- Writes to 0xFF50:
  - Write 0x00: `boot_active` stays 1.
  - Then write 0x01: `boot_active` = 0, a read of 0x0000 returns 0xFF, and a read of 0xFF50 returns 0xFF.
  - A following write of 0x00 leaves `boot_active` = 0.
- Write 0xA5 to 0xFFFE and 0x3C to 0xFF80, then read both back:
  - Returns 0xA5 and 0x3C.
  - A read of 0xFFFF returns 0xFF.
- Assert `cs=oe=we=1` with address 0xC000 and data 0x77:
  - `bus_err` pulses for one cycle.
  - The bus stays high-Z.
  - A later read of 0xC000 returns its prior value.
- Hold `cs=oe` and step the address 0xC000 → 0xC001:
  - One high-Z gap cycle, then the 0xC001 data.
- Assert `rst` while in RD_DRIVE:
  - The bus is high-Z immediately (asynchronous).
  - `boot_active` = 1.
